// File: rtl/lift_ext_stream_bridge.sv
// Host-side bridge for the lift external-access address controller.
// Writes: stage a whole input burst, then let the controller walk ext_addr while
// ibuff_wdata follows stage[ext_addr]. Reads: start a controller obuff burst only
// when the output FIFO can absorb it, so the controller is never stalled.
module lift_ext_stream_bridge #(
  parameter int unsigned W        = 64,
  parameter int unsigned WR_SMALL = 6,
  parameter int unsigned WR_LARGE = 13,
  parameter int unsigned RD_SMALL = 7,
  parameter int unsigned RD_LARGE = 6,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned OF_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic         cmd_mode,
  output logic         cmd_done,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         ctrl_rst,
  output logic         ctrl_read_write,
  output logic         ctrl_lift_mode,
  input  logic [3:0]   ext_addr,
  input  logic         ext_ctrl_done,
  output logic [W-1:0] ibuff_wdata,
  input  logic         result_read_en,
  input  logic [W-1:0] obuff_rdata
);

  localparam int unsigned PtrW = $clog2(OF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned FlW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [3:0] LenWrS = 4'(WR_SMALL);
  localparam logic [3:0] LenWrL = 4'(WR_LARGE);
  localparam logic [3:0] LenRdS = 4'(RD_SMALL);
  localparam logic [3:0] LenRdL = 4'(RD_LARGE);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWrite,
    StRwait,
    StRead,
    StRflush
  } state_e;

  state_e state_q, state_d;

  logic            op_q, mode_q;
  logic [3:0]      len_q, len_sel;
  logic [3:0]      cnt_q;
  logic            cmd_ready_q, cmd_done_q;
  logic [FlW-1:0]  flush_q;
  logic [W-1:0]    stage_q [WR_LARGE];

  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [CntW-1:0]   inflight;
  logic [15:0]       need;
  logic              room_ok;

  logic [W-1:0]    fifo_q [OF_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;

  logic accept, s_fire, strobe, push, pop, flush_last;

  assign accept     = cmd_valid & cmd_ready_q;
  assign s_ready    = (state_q == StFill) && (cnt_q < len_q);
  assign s_fire     = s_valid & s_ready;
  assign strobe     = result_read_en && (state_q == StRead);
  assign push       = rd_pipe_q[RD_LAT-1];
  assign pop        = m_valid & m_ready;
  assign flush_last = (flush_q == FlW'(RD_LAT - 1));

  assign cmd_ready       = cmd_ready_q;
  assign cmd_done        = cmd_done_q;
  assign ctrl_rst        = !((state_q == StWrite) || (state_q == StRead));
  assign ctrl_read_write = op_q;
  assign ctrl_lift_mode  = mode_q;
  assign m_valid         = (count_q != '0);
  assign m_data          = fifo_q[rptr_q];
  assign ibuff_wdata     = (32'(ext_addr) < WR_LARGE) ? stage_q[ext_addr] : '0;

  // Burst length selected by the incoming command.
  always_comb begin
    len_sel = cmd_op ? (cmd_mode ? LenRdL : LenRdS) : (cmd_mode ? LenWrL : LenWrS);
  end

  // Read strobe delay line; also counts words still in flight towards the FIFO.
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = strobe;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight = inflight + CntW'(rd_pipe_q[i]);
    end
    need    = 16'(count_q) + 16'(inflight) + 16'(len_q);
    room_ok = (need <= 16'(OF_DEPTH));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = cmd_op ? StRwait : StFill;
      StFill:   if (cnt_q == len_q) state_d = StWrite;
      StWrite:  if (ext_ctrl_done) state_d = StIdle;
      StRwait:  if (room_ok) state_d = StRead;
      StRead:   if (ext_ctrl_done) state_d = StRflush;
      StRflush: if (flush_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control registers: FSM, command latch, stage count, handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      flush_q     <= '0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == StIdle);
      cmd_done_q  <= ((state_q == StWrite) && ext_ctrl_done) ||
                     ((state_q == StRflush) && flush_last);
      rd_pipe_q   <= rd_pipe_d;
      if (accept) begin
        op_q   <= cmd_op;
        mode_q <= cmd_mode;
        len_q  <= len_sel;
      end
      if (s_fire) begin
        cnt_q <= cnt_q + 4'd1;
      end else if ((state_q == StWrite) && ext_ctrl_done) begin
        cnt_q <= '0;
      end
      flush_q <= (state_q == StRflush) ? flush_q + FlW'(1) : '0;
    end
  end

  // Staging buffer for the write burst; contents need no reset.
  always_ff @(posedge clk) begin
    if (s_fire) stage_q[cnt_q] <= s_data;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= obuff_rdata;
  end

  // RWAIT admission must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CntW'(OF_DEPTH))));

endmodule

// File: tb/tb_lift_ext_stream_bridge.sv
// Bench for lift_ext_stream_bridge: a simple controller model drives ext_addr,
// and a burst-level reference model predicts every output each cycle.
module tb_lift_ext_stream_bridge;
  localparam int W        = 64;
  localparam int RD_LAT   = 1;
  localparam int OF_DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_op, cmd_mode, cmd_done;
  logic         s_valid, s_ready;
  logic [W-1:0] s_data;
  logic         m_valid, m_ready;
  logic [W-1:0] m_data;
  logic         ctrl_rst, ctrl_read_write, ctrl_lift_mode;
  logic [3:0]   ext_addr, c_last;
  logic         ext_ctrl_done, result_read_en;
  logic [W-1:0] ibuff_wdata, obuff_rdata;
  logic [W-1:0] obuff_base;

  always #5 clk = ~clk;

  lift_ext_stream_bridge dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_done(cmd_done), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ctrl_rst(ctrl_rst), .ctrl_read_write(ctrl_read_write), .ctrl_lift_mode(ctrl_lift_mode),
    .ext_addr(ext_addr), .ext_ctrl_done(ext_ctrl_done), .ibuff_wdata(ibuff_wdata),
    .result_read_en(result_read_en), .obuff_rdata(obuff_rdata)
  );

  // Controller stand-in: counts 0..last while released, held at 0 by ctrl_rst.
  always_comb begin
    c_last = ctrl_read_write ? (ctrl_lift_mode ? 4'd5 : 4'd6)
                             : (ctrl_lift_mode ? 4'd12 : 4'd5);
  end
  always_ff @(posedge clk) begin
    if (rst || ctrl_rst)      ext_addr <= 4'd0;
    else if (ext_addr != c_last) ext_addr <= ext_addr + 4'd1;
    obuff_rdata <= obuff_base + W'(ext_addr);
  end
  assign ext_ctrl_done  = !ctrl_rst && (ext_addr == c_last);
  assign result_read_en = !ctrl_rst && ctrl_read_write;

  int vec = 0, fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vec++;
    fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- reference model ----------------
  int           cyc = 0;
  bit           busy = 0, m_op = 0, m_mode = 0, done_seen = 0, prev_rst = 1, pend_v = 0;
  bit           exp_cr;
  int           m_len = 0, filled = 0, actives = 0, exp_done_at = -1, last_active = -100;
  int           last_done_cyc = 0, last_cmd_done_cyc = 0;
  logic [W-1:0] wstage [16];
  logic [W-1:0] pend_d;
  logic [W-1:0] mq[$], order_q[$], wr_seen[$], rd_seen[$];

  // Per-cycle compare against the burst-level model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 0; exp_done_at = -1; pend_v = 0; prev_rst = 1;
        filled = 0; actives = 0; done_seen = 0;
        mq.delete(); order_q.delete();
      end else begin
        chk("cmd_done", W'(cmd_done), W'(cyc == exp_done_at));
        if (cmd_done) last_cmd_done_cyc = cyc;
        if (cyc == exp_done_at) begin busy = 0; exp_done_at = -1; end
        exp_cr = !busy && !prev_rst;
        chk("cmd_ready", W'(cmd_ready), W'(exp_cr));
        chk("s_ready", W'(s_ready), W'(busy && !m_op && filled < m_len));
        chk("m_valid", W'(m_valid), W'(mq.size() != 0));
        if (m_valid && mq.size() != 0) chk("m_data", m_data, mq[0]);
        if (!ctrl_rst) begin
          chk("ctrl_active_only_in_burst", W'(busy && !done_seen), W'(1));
          chk("ctrl_read_write", W'(ctrl_read_write), W'(m_op));
          chk("ctrl_lift_mode", W'(ctrl_lift_mode), W'(m_mode));
          if (actives == 0) chk("ctrl_rst_gap", W'(cyc - last_active >= 2), W'(1));
          last_active = cyc;
          if (!m_op) begin
            chk("write_after_full_fill", W'(filled == m_len), W'(1));
            chk("ibuff_wdata", ibuff_wdata, wstage[ext_addr]);
            wr_seen.push_back(ibuff_wdata);
          end else if (actives == 0) begin
            chk("fifo_room_at_read_start",
                W'(mq.size() + (pend_v ? 1 : 0) + m_len <= OF_DEPTH), W'(1));
          end
          actives++;
          if (ext_ctrl_done) begin
            chk("burst_len", W'(actives), W'(m_len));
            done_seen = 1;
            last_done_cyc = cyc;
            exp_done_at = cyc + (m_op ? 1 + RD_LAT : 1);
          end
        end
        if (m_valid && m_ready) begin
          if (mq.size() != 0) void'(mq.pop_front());
          chk("pop_expected", W'(order_q.size() != 0), W'(1));
          if (order_q.size() != 0) chk("m_order", m_data, order_q.pop_front());
          rd_seen.push_back(m_data);
        end
        if (pend_v) mq.push_back(pend_d);
        pend_v = !ctrl_rst && ctrl_read_write;
        pend_d = obuff_base + W'(ext_addr);
        if (s_valid && busy && !m_op && filled < m_len) begin
          wstage[filled] = s_data;
          filled++;
        end
        if (cmd_valid && exp_cr) begin
          busy = 1; m_op = cmd_op; m_mode = cmd_mode;
          m_len = cmd_op ? (cmd_mode ? 6 : 7) : (cmd_mode ? 13 : 6);
          filled = 0; actives = 0; done_seen = 0;
          if (cmd_op) for (int i = 0; i < m_len; i++) order_q.push_back(obuff_base + W'(i));
        end
        prev_rst = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit           mr_rand = 0;
  logic [W-1:0] words [16];

  task automatic tick();
    @(posedge clk);
    #1;
    if (mr_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input bit op, input bit mode);
    int g = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode;
    @(negedge clk);
    while (!cmd_ready && g < 3000) begin
      tick(); @(negedge clk); g++;
    end
    if (g >= 3000) timeout("cmd_accept");
    tick();
    cmd_valid = 1'b0;
  endtask

  // gap: 0 = always valid, 1 = idle every 3rd cycle, 2 = random
  task automatic feed(input int n, input int gap);
    int idx = 0, g = 0;
    bit fire;
    while (idx < n && g < 5000) begin
      s_valid = (gap == 1) ? (g % 3 != 2) : (gap == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = words[idx];
      @(negedge clk);
      fire = s_valid && s_ready;
      tick();
      if (fire) idx++;
      g++;
    end
    if (idx < n) timeout("feed");
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    @(negedge clk);
    while (!cmd_done && g < limit) begin
      tick(); @(negedge clk); g++;
    end
    if (g >= limit) timeout("cmd_done");
    tick();
  endtask

  task automatic drain();
    int g = 0;
    m_ready = 1'b1;
    while ((mq.size() != 0 || order_q.size() != 0) && g < 500) begin tick(); g++; end
    if (g >= 500) timeout("drain");
  endtask

  initial begin
    int  held, dones;
    bit  op, mode;
    rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_mode = 0; s_valid = 0; s_data = '0;
    m_ready = 0; obuff_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", W'(cmd_ready), W'(0));
    chk("rst_cmd_done", W'(cmd_done), W'(0));
    chk("rst_s_ready", W'(s_ready), W'(0));
    chk("rst_m_valid", W'(m_valid), W'(0));
    chk("rst_ctrl_rst", W'(ctrl_rst), W'(1));
    chk("rst_ctrl_rw", W'(ctrl_read_write), W'(0));
    chk("rst_ctrl_mode", W'(ctrl_lift_mode), W'(0));
    tick();
    rst = 1'b0;
    tick();

    // T1 small write, data 10..15
    for (int i = 0; i < 6; i++) words[i] = W'(10 + i);
    wr_seen.delete();
    issue(0, 0); feed(6, 0); wait_done(100);
    chk("t1_count", W'(wr_seen.size()), W'(6));
    for (int i = 0; i < 6 && i < wr_seen.size(); i++) chk("t1_wdata", wr_seen[i], W'(10 + i));
    chk("t1_done_lag", W'(last_cmd_done_cyc - last_done_cyc), W'(1));

    // T2 large write with gaps, then s_valid held high past the burst
    for (int i = 0; i < 13; i++) words[i] = {$urandom, $urandom};
    wr_seen.delete();
    issue(0, 1); feed(13, 1);
    s_valid = 1'b1; s_data = 64'hdead_beef_0bad_f00d;
    wait_done(100);
    s_valid = 1'b0;
    chk("t2_count", W'(wr_seen.size()), W'(13));
    for (int i = 0; i < 13 && i < wr_seen.size(); i++) chk("t2_wdata", wr_seen[i], words[i]);

    // T3 small read, obuff data 100+addr
    m_ready = 1'b1; obuff_base = W'(100); rd_seen.delete();
    issue(1, 0); wait_done(100);
    repeat (3) tick();
    chk("t3_count", W'(rd_seen.size()), W'(7));
    for (int i = 0; i < 7 && i < rd_seen.size(); i++) chk("t3_data", rd_seen[i], W'(100 + i));
    chk("t3_done_lag", W'(last_cmd_done_cyc - last_done_cyc), W'(1 + RD_LAT));

    // T4 backpressure: 14 words parked, third read needs 5 pops to fit 7
    m_ready = 1'b0; obuff_base = {$urandom, $urandom};
    issue(1, 0); wait_done(100);
    issue(1, 0); wait_done(100);
    chk("t4_fifo_14", W'(mq.size()), W'(14));
    issue(1, 0);
    held = 1;
    repeat (20) begin @(negedge clk); if (!ctrl_rst) held = 0; tick(); end
    chk("t4_held_full", W'(held), W'(1));
    m_ready = 1'b1; repeat (4) tick(); m_ready = 1'b0;
    repeat (10) begin @(negedge clk); if (!ctrl_rst) held = 0; tick(); end
    chk("t4_held_after_4_pops", W'(held), W'(1));
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    wait_done(50);
    chk("t4_fifo_full", W'(mq.size()), W'(16));
    drain();

    // T5 back-to-back write then read
    for (int i = 0; i < 6; i++) words[i] = {$urandom, $urandom};
    issue(0, 0); feed(6, 0); wait_done(100);
    issue(1, 1); wait_done(100);
    drain();

    // T6 reset at ext_addr 7 of a large write, with read data parked in the FIFO
    m_ready = 1'b0;
    issue(1, 0); wait_done(100);
    for (int i = 0; i < 13; i++) words[i] = {$urandom, $urandom};
    issue(0, 1); feed(13, 0);
    held = 0;
    @(negedge clk);
    while (!(!ctrl_rst && ext_addr == 4'd6) && held < 100) begin
      tick(); @(negedge clk); held++;
    end
    if (held >= 100) timeout("t6_addr6");
    tick();
    chk("t6_addr7", W'(ext_addr), W'(7));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_cmd_ready", W'(cmd_ready), W'(0));
    chk("t6_cmd_done", W'(cmd_done), W'(0));
    chk("t6_s_ready", W'(s_ready), W'(0));
    chk("t6_m_valid", W'(m_valid), W'(0));
    chk("t6_ctrl_rst", W'(ctrl_rst), W'(1));
    chk("t6_ctrl_rw", W'(ctrl_read_write), W'(0));
    chk("t6_ctrl_mode", W'(ctrl_lift_mode), W'(0));
    tick();
    rst = 1'b0;
    dones = 0;
    repeat (20) begin @(negedge clk); if (cmd_done) dones++; tick(); end
    chk("t6_no_done", W'(dones), W'(0));

    // Random mix of bursts with random backpressure
    mr_rand = 1;
    for (int n = 0; n < 40; n++) begin
      op = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
      if (!op) begin
        for (int i = 0; i < 13; i++) words[i] = {$urandom, $urandom};
        issue(0, mode); feed(mode ? 13 : 6, 2); wait_done(200);
      end else begin
        obuff_base = {$urandom, $urandom};
        issue(1, mode); wait_done(2000);
      end
    end
    mr_rand = 0;
    drain();
    chk("final_order_empty", W'(order_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
